// File: rtl/evt_stream_arb_if.sv
// AXI-Stream bundle carrying LANES parallel streams packed lane-major.
// The arbiter uses a NUM_SRC-lane instance upstream and a single-lane instance downstream.
interface evt_stream_arb_if #(
  parameter int LANES  = 1,
  parameter int DATA_W = 128,
  parameter int TID_W  = 11
);
  localparam int SW = DATA_W / 8;

  logic [LANES-1:0]        TVALID;
  logic [LANES-1:0]        TREADY;
  logic [LANES*DATA_W-1:0] TDATA;
  logic [LANES*SW-1:0]     TSTRB;
  logic [LANES*SW-1:0]     TKEEP;
  logic [LANES-1:0]        TLAST;
  logic [LANES*TID_W-1:0]  TID;

  modport master (output TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, input TREADY);
  modport slave  (input TVALID, TDATA, TSTRB, TKEEP, TLAST, TID, output TREADY);
endinterface

// File: rtl/evt_stream_arb.sv
// Packet-level round-robin arbiter: NUM_SRC event streams onto one AXI-Stream, 1-cycle output register.
// Grant is held until the owner's TLAST is accepted; owner ready follows ~m_TVALID | m_TREADY.
module evt_stream_arb #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 128,
  parameter int TID_W   = 11
) (
  input  logic                       clk,
  input  logic                       ARESETn,
  evt_stream_arb_if.slave            s_axis,
  evt_stream_arb_if.master           m_axis,
  output logic [$clog2(NUM_SRC)-1:0] m_TDEST,
  output logic                       busy,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx
);
  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int SW    = DATA_W / 8;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t             state;
  logic [IDX_W-1:0]   g;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   sel;
  logic [NUM_SRC-1:0] rdy;
  logic               any_vld;
  logic               out_ok;
  logic               s_acc;

  logic               g_vld;
  logic               g_last;
  logic [DATA_W-1:0]  g_dat;
  logic [SW-1:0]      g_strb;
  logic [SW-1:0]      g_keep;
  logic [TID_W-1:0]   g_tid;

  assign grant_idx = g;
  assign busy      = (state == LOCK);
  assign any_vld   = |s_axis.TVALID;
  assign out_ok    = ~m_axis.TVALID[0] | m_axis.TREADY[0];
  assign s_acc     = (state == LOCK) & g_vld & out_ok;
  assign s_axis.TREADY = rdy;

  // First valid source strictly after ptr, wrapping; ptr is the last packet's owner.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] j;
    sel   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      j = IDX_W'((int'(ptr) + k) % NUM_SRC);
      if (!found && s_axis.TVALID[j]) begin
        found = 1'b1;
        sel   = j;
      end
    end
  end

  always_comb begin
    g_vld  = 1'b0;
    g_last = 1'b0;
    g_dat  = '0;
    g_strb = '0;
    g_keep = '0;
    g_tid  = '0;
    rdy    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (g == IDX_W'(i)) begin
        g_vld  = s_axis.TVALID[i];
        g_last = s_axis.TLAST[i];
        g_dat  = s_axis.TDATA[i*DATA_W +: DATA_W];
        g_strb = s_axis.TSTRB[i*SW +: SW];
        g_keep = s_axis.TKEEP[i*SW +: SW];
        g_tid  = s_axis.TID[i*TID_W +: TID_W];
        rdy[i] = (state == LOCK) & out_ok;
      end
    end
  end

  always_ff @(posedge clk or negedge ARESETn) begin
    if (!ARESETn) begin
      state         <= IDLE;
      g             <= '0;
      ptr           <= IDX_W'(NUM_SRC - 1);
      m_axis.TVALID <= '0;
      m_axis.TDATA  <= '0;
      m_axis.TSTRB  <= '0;
      m_axis.TKEEP  <= '0;
      m_axis.TLAST  <= '0;
      m_axis.TID    <= '0;
      m_TDEST       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_vld) begin
            g     <= sel;
            state <= LOCK;
          end
        end
        LOCK: begin
          if (s_acc && g_last) begin
            ptr   <= g;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // The output register may still hold the previous TLAST while the next grant is taken.
      if (s_acc) begin
        m_axis.TVALID <= 1'b1;
        m_axis.TDATA  <= g_dat;
        m_axis.TSTRB  <= g_strb;
        m_axis.TKEEP  <= g_keep;
        m_axis.TLAST  <= g_last;
        m_axis.TID    <= g_tid;
        m_TDEST       <= g;
      end else if (m_axis.TREADY[0]) begin
        m_axis.TVALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_evt_stream_arb.sv
// Bench for evt_stream_arb: fixed vector table, scripted corner cases and a random run
// against a packet-level reference model of the arbitration rules.
module tb_evt_stream_arb;
  localparam int N  = 4;
  localparam int DW = 128;
  localparam int TW = 11;
  localparam int SW = DW / 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic ARESETn = 1'b0;
  always #5 clk = ~clk;

  evt_stream_arb_if #(.LANES(N), .DATA_W(DW), .TID_W(TW)) s_if ();
  evt_stream_arb_if #(.LANES(1), .DATA_W(DW), .TID_W(TW)) m_if ();
  logic [IW-1:0] m_TDEST;
  logic [IW-1:0] grant_idx;
  logic          busy;

  evt_stream_arb #(.NUM_SRC(N), .DATA_W(DW), .TID_W(TW)) dut (
    .clk(clk), .ARESETn(ARESETn), .s_axis(s_if), .m_axis(m_if),
    .m_TDEST(m_TDEST), .busy(busy), .grant_idx(grant_idx)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] vld, lst;
    logic       rdy;
    logic [7:0] tag;
    logic       eb;
    logic [3:0] esr;
    logic       emv;
    logic [7:0] et;
    logic [1:0] ed;
    logic       el;
  } vec_t;

  function automatic vec_t mk(logic [3:0] vld, logic [3:0] lst, logic rdy, logic [7:0] tag, logic eb,
                              logic [3:0] esr, logic emv, logic [7:0] et, logic [1:0] ed, logic el);
    vec_t v;
    v.vld = vld; v.lst = lst; v.rdy = rdy; v.tag = tag; v.eb = eb;
    v.esr = esr; v.emv = emv; v.et = et; v.ed = ed; v.el = el;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] dat;
    logic [SW-1:0] strb, keep;
    logic          last;
    logic [TW-1:0] tid;
  } beat_t;

  beat_t src_q[N][$];
  bit    src_on[N];
  bit    pend;
  int    owner, last_g, out_d, acc_cnt;
  bit    out_full;
  beat_t out_b;
  int    pkt_order[$];
  int    dest_seq[$];

  task automatic reset_model();
    for (int i = 0; i < N; i++) src_q[i].delete();
    pend = 1; owner = 0; last_g = N - 1; out_full = 0; acc_cnt = 0;
    pkt_order.delete(); dest_seq.delete();
  endtask

  task automatic add_pkt(input int s, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.dat  = {$urandom, $urandom, $urandom, $urandom};
      b.strb = SW'($urandom);
      b.keep = SW'($urandom);
      b.tid  = TW'($urandom);
      b.last = (k == len - 1);
      src_q[s].push_back(b);
    end
  endtask

  function automatic bit model_idle();
    bit e;
    e = pend && !out_full;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) e = 0;
    return e;
  endfunction

  task automatic drive_srcs();
    for (int i = 0; i < N; i++) begin
      beat_t b;
      bit    v;
      v = src_on[i] && (src_q[i].size() > 0);
      b = '{default: '0};
      if (v) b = src_q[i][0];
      s_if.TVALID[i]              = v;
      s_if.TLAST[i]               = b.last;
      s_if.TDATA[i*DW +: DW]      = b.dat;
      s_if.TSTRB[i*SW +: SW]      = b.strb;
      s_if.TKEEP[i*SW +: SW]      = b.keep;
      s_if.TID[i*TW +: TW]        = b.tid;
    end
  endtask

  // Called between edges: checks outputs, then advances the model across the next edge.
  task automatic model_cycle();
    logic [N-1:0] vld, esr;
    bit ok, sacc, macc, pend0, found;
    int j;
    vld = s_if.TVALID;
    ok  = !out_full || m_if.TREADY[0];
    esr = (!pend && ok) ? (N'(1) << owner) : '0;
    chk("busy", busy, !pend);
    chk("s_TREADY", s_if.TREADY, esr);
    chk("m_TVALID", m_if.TVALID, out_full);
    chk("grant_idx", grant_idx, owner);
    if (out_full) begin
      chk("m_TDATA", m_if.TDATA, out_b.dat);
      chk("m_meta", {m_if.TLAST, m_if.TID, m_TDEST, m_if.TSTRB, m_if.TKEEP},
          {out_b.last, out_b.tid, IW'(out_d), out_b.strb, out_b.keep});
    end
    pend0 = pend;
    sacc  = !pend0 && vld[owner[IW-1:0]] && ok;
    macc  = out_full && m_if.TREADY[0];
    if (macc) dest_seq.push_back(out_d);
    if (pend0 && |vld) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        j = (last_g + k) % N;
        if (!found && vld[j[IW-1:0]]) begin
          found = 1;
          owner = j;
        end
      end
      pend = 0;
      pkt_order.push_back(owner);
    end
    if (sacc) begin
      out_b    = src_q[owner].pop_front();
      out_d    = owner;
      out_full = 1;
      acc_cnt++;
      if (out_b.last) begin
        last_g = owner;
        pend   = 1;
      end
    end else if (macc) begin
      out_full = 0;
    end
  endtask

  task automatic set_inputs(input int mode, input int c);
    for (int i = 0; i < N; i++) begin
      if (mode == 0) src_on[i] = ($urandom_range(0, 3) != 0);
      else if (mode == 1) src_on[i] = 1;
      else src_on[i] = 0;
    end
    if (mode == 2) begin
      src_on[1] = !(c >= 4 && c <= 6);
      src_on[3] = (c >= 2);
    end
    m_if.TREADY[0] = (mode == 0) ? ($urandom_range(0, 9) < 7) : 1'b1;
  endtask

  task automatic run(input int mode, input int max, input bit need_drain, input int stop_acc);
    bit drained;
    drained = 0;
    for (int c = 0; c < max; c++) begin
      set_inputs(mode, c);
      drive_srcs();
      @(negedge clk);
      model_cycle();
      @(posedge clk);
      #1;
      if (stop_acc >= 0 && acc_cnt >= stop_acc) break;
      if (need_drain && model_idle()) begin
        drained = 1;
        break;
      end
    end
    if (need_drain) chk("drain_timeout", drained, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vt[23];
    int   sent;
    s_if.TVALID = '0; s_if.TLAST = '0; s_if.TDATA = '0;
    s_if.TSTRB = '0; s_if.TKEEP = '0; s_if.TID = '0;
    m_if.TREADY = '0;
    for (int i = 0; i < N; i++) src_on[i] = 0;

    // Reset held for 3 cycles, then released with nothing valid.
    repeat (3) begin
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_m_TVALID", m_if.TVALID, 1'b0);
      chk("rst_s_TREADY", s_if.TREADY, '0);
    end
    @(posedge clk); #1;
    ARESETn = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_s_TREADY", s_if.TREADY, '0);
    chk("idle_m_TVALID", m_if.TVALID, 1'b0);
    chk("idle_m_TDATA", m_if.TDATA, '0);
    chk("idle_m_meta", {m_if.TLAST, m_if.TID, m_TDEST, m_if.TSTRB, m_if.TKEEP}, '0);
    chk("idle_grant_idx", grant_idx, '0);

    // Source 2 4-beat packet; source 0 packet with 5-cycle backpressure; single-beat on source 3.
    vt[0]  = mk(4'h4, 4'h0, 1, 8'd1, 0, 4'h0, 0, 8'd0, 2'd0, 0);
    vt[1]  = mk(4'h4, 4'h0, 1, 8'd1, 1, 4'h4, 0, 8'd0, 2'd0, 0);
    vt[2]  = mk(4'h4, 4'h0, 1, 8'd2, 1, 4'h4, 1, 8'd1, 2'd2, 0);
    vt[3]  = mk(4'h4, 4'h0, 1, 8'd3, 1, 4'h4, 1, 8'd2, 2'd2, 0);
    vt[4]  = mk(4'h4, 4'h4, 1, 8'd4, 1, 4'h4, 1, 8'd3, 2'd2, 0);
    vt[5]  = mk(4'h0, 4'h0, 1, 8'd0, 0, 4'h0, 1, 8'd4, 2'd2, 1);
    vt[6]  = mk(4'h0, 4'h0, 1, 8'd0, 0, 4'h0, 0, 8'd0, 2'd0, 0);
    vt[7]  = mk(4'h1, 4'h0, 1, 8'd5, 0, 4'h0, 0, 8'd0, 2'd0, 0);
    vt[8]  = mk(4'h1, 4'h0, 1, 8'd5, 1, 4'h1, 0, 8'd0, 2'd0, 0);
    for (int r = 9; r <= 13; r++)
      vt[r] = mk(4'h1, 4'h0, 0, 8'd6, 1, 4'h0, 1, 8'd5, 2'd0, 0);
    vt[14] = mk(4'h1, 4'h0, 1, 8'd6, 1, 4'h1, 1, 8'd5, 2'd0, 0);
    vt[15] = mk(4'h1, 4'h1, 1, 8'd7, 1, 4'h1, 1, 8'd6, 2'd0, 0);
    vt[16] = mk(4'h0, 4'h0, 0, 8'd0, 0, 4'h0, 1, 8'd7, 2'd0, 1);
    vt[17] = mk(4'h0, 4'h0, 1, 8'd0, 0, 4'h0, 1, 8'd7, 2'd0, 1);
    vt[18] = mk(4'h0, 4'h0, 1, 8'd0, 0, 4'h0, 0, 8'd0, 2'd0, 0);
    vt[19] = mk(4'h8, 4'h8, 1, 8'd9, 0, 4'h0, 0, 8'd0, 2'd0, 0);
    vt[20] = mk(4'h8, 4'h8, 1, 8'd9, 1, 4'h8, 0, 8'd0, 2'd0, 0);
    vt[21] = mk(4'h0, 4'h0, 1, 8'd0, 0, 4'h0, 1, 8'd9, 2'd3, 1);
    vt[22] = mk(4'h0, 4'h0, 1, 8'd0, 0, 4'h0, 0, 8'd0, 2'd0, 0);

    for (int r = 0; r < 23; r++) begin
      @(posedge clk); #1;
      s_if.TVALID = vt[r].vld;
      s_if.TLAST  = vt[r].lst;
      s_if.TSTRB  = '1;
      s_if.TKEEP  = '1;
      for (int i = 0; i < N; i++) begin
        s_if.TDATA[i*DW +: DW] = DW'({vt[r].tag, 4'(i)});
        s_if.TID[i*TW +: TW]   = TW'(6 + i);
      end
      m_if.TREADY[0] = vt[r].rdy;
      @(negedge clk);
      chk($sformatf("vec%0d busy", r), busy, vt[r].eb);
      chk($sformatf("vec%0d s_TREADY", r), s_if.TREADY, vt[r].esr);
      chk($sformatf("vec%0d m_TVALID", r), m_if.TVALID, vt[r].emv);
      if (vt[r].emv) begin
        chk($sformatf("vec%0d m_TDATA", r), m_if.TDATA, DW'({vt[r].et, 2'b00, vt[r].ed}));
        chk($sformatf("vec%0d m_TID", r), m_if.TID, TW'(6 + vt[r].ed));
        chk($sformatf("vec%0d m_TDEST", r), m_TDEST, vt[r].ed);
        chk($sformatf("vec%0d m_TLAST", r), m_if.TLAST, vt[r].el);
      end
    end

    // Fresh reset so the model starts in step with the DUT.
    @(posedge clk); #1;
    ARESETn = 1'b0;
    @(posedge clk); #1;
    ARESETn = 1'b1;
    reset_model();

    // Round-robin with every source holding 2-beat packets.
    for (int s = 0; s < N; s++) for (int p = 0; p < 3; p++) add_pkt(s, 2);
    run(1, 200, 1, -1);
    for (int i = 0; i < 10; i++)
      chk($sformatf("rr_dest%0d", i), (dest_seq.size() > i) ? dest_seq[i] : 99, (i / 2) % N);

    // Source 1 stalls mid-packet while source 3 waits.
    pkt_order.delete();
    add_pkt(1, 5);
    add_pkt(3, 2);
    run(2, 100, 1, -1);
    chk("stall_pkts", pkt_order.size(), 2);
    chk("stall_first", (pkt_order.size() > 0) ? pkt_order[0] : -1, 1);
    chk("stall_second", (pkt_order.size() > 1) ? pkt_order[1] : -1, 3);

    // Random traffic, gaps and backpressure.
    dest_seq.delete();
    sent = 0;
    for (int p = 0; p < 150; p++) begin
      int len;
      len = $urandom_range(1, 5);
      sent += len;
      add_pkt($urandom_range(0, N - 1), len);
    end
    run(0, 1500, 0, -1);
    run(1, 2000, 1, -1);
    chk("rand_beats", dest_seq.size(), sent);

    // Reset at beat 2 of a 6-beat packet on source 0.
    add_pkt(0, 6);
    acc_cnt = 0;
    run(1, 50, 0, 2);
    ARESETn = 1'b0;
    #1;
    chk("midrst_m_TVALID", m_if.TVALID, 1'b0);
    chk("midrst_s_TREADY", s_if.TREADY, '0);
    chk("midrst_busy", busy, 1'b0);
    @(posedge clk); #1;
    reset_model();
    add_pkt(2, 1);
    add_pkt(0, 2);
    ARESETn = 1'b1;
    run(1, 100, 1, -1);
    chk("midrst_first_grant", (pkt_order.size() > 0) ? pkt_order[0] : -1, 0);
    chk("midrst_beats", dest_seq.size(), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/evt_stream_arb.md
# evt_stream_arb

Packet-level round-robin arbiter that shares one AXI-Stream downstream channel among `NUM_SRC` event-readout adaptor streams. Each source streams whole events terminated by TLAST, tagged with a BCID on TID. The arbiter grants one source at a time and holds the grant until that source's TLAST beat is accepted. Accepted beats pass through a one-entry output register, and a source index is presented on `m_TDEST`. It sits between the per-buffer upstream adaptors and the single downstream AXI-Stream consumer.

## Interface
- `NUM_SRC`, 4: number of source streams (2..16).
- `DATA_W`, 128: TDATA width in bits; TSTRB/TKEEP width is `DATA_W/8`.
- `TID_W`, 11: TID (BCID) width.
- `clk` in 1: single clock, rising edge.
- `ARESETn` in 1: reset, asynchronous assert, active-low.
- `s_TVALID` in NUM_SRC: per-source valid.
- `s_TREADY` out NUM_SRC: per-source ready.
- `s_TDATA` in NUM_SRC*DATA_W: packed; source i occupies slice i.
- `s_TSTRB`, `s_TKEEP` in NUM_SRC*DATA_W/8: packed byte qualifiers.
- `s_TLAST` in NUM_SRC: last beat of event.
- `s_TID` in NUM_SRC*TID_W: packed BCID.
- `m_TVALID` out 1; `m_TREADY` in 1.
- `m_TDATA` out DATA_W; `m_TSTRB`, `m_TKEEP` out DATA_W/8; `m_TLAST` out 1; `m_TID` out TID_W.
- `m_TDEST` out clog2(NUM_SRC): index of the source that produced the beat.
- `busy` out 1: high while a grant is held (state LOCK).
- `grant_idx` out clog2(NUM_SRC): currently or last granted source.

## Operation
- **States.** IDLE (no grant) and LOCK (grant held on source `g`).
- **IDLE.**
  - All `s_TREADY` are 0.
  - If any `s_TVALID` is high, select the first valid source scanning from `ptr+1` upward, wrapping modulo NUM_SRC.
  - Register the selection as `g` and go to LOCK.
  - No beat transfers in IDLE.
- **LOCK.**
  - `s_TREADY[g] = ~m_TVALID | m_TREADY`. All other `s_TREADY` are 0.
  - Source beat accepted (`s_TVALID[g] & s_TREADY[g]`):
    - Load the output register with source g's DATA/STRB/KEEP/LAST/TID.
    - Set `m_TDEST = g` and `m_TVALID <= 1`.
  - Output drained with no new beat (`m_TVALID & m_TREADY` and no source accept): `m_TVALID <= 0`.
  - Accepted source beat with `s_TLAST = 1`: `ptr <= g`, go to IDLE.
- **Lock hold.** If `s_TVALID[g]` drops mid-packet, the grant is held. No other source is served until g delivers TLAST.
- **Early re-arbitration.** The TLAST beat may still sit in the output register when the next grant is taken. The new source's ready stays low until the register drains, via the same `~m_TVALID | m_TREADY` rule.
- **Output register.** `m_*` hold stable while `m_TVALID & ~m_TREADY`, per AXI-Stream.
- **Fairness.** The priority pointer rotates per packet, not per beat. With all sources requesting, the service order is 0, 1, …, NUM_SRC-1, 0.

## Timing
- **Reset values** (asynchronous, while `ARESETn = 0`):
  - `m_TVALID`, `m_TLAST`, `m_TDATA`, `m_TSTRB`, `m_TKEEP`, `m_TID`, `m_TDEST`, `busy`, `grant_idx` are 0; `s_TREADY` is all 0.
  - State is IDLE and `ptr = NUM_SRC-1`, so source 0 wins first.
- **Reset mid-packet.** Aborts the packet immediately; outputs return to the reset values. A partial packet is not completed after reset release.
- **Grant latency.** Source valid in IDLE at cycle N → `busy = 1` and `s_TREADY[g] = 1` in cycle N+1.
- **Output latency.** A beat accepted at edge E appears on `m_*` after E (1-cycle latency).
- **Throughput.** One beat per cycle inside a packet when `m_TREADY` is held high. There is exactly one bubble cycle (IDLE) between consecutive packets.
- **Backpressure.** With `m_TREADY = 0` and `m_TVALID = 1`, `s_TREADY[g]` is 0 in the same cycle (combinational from `m_TREADY`).
- **Single-beat packet** (TLAST on first beat): LOCK lasts one cycle.

## Test plan
- **Reset and idle.** Hold `ARESETn = 0` for 3 cycles, then release with no valid → all outputs 0; `busy = 0` throughout.
- **Single source.** Source 2 sends a 4-beat packet with TID = 8 and `m_TREADY = 1` → `busy` rises one cycle after valid. `m_TVALID` is high for 4 consecutive cycles with `m_TDEST = 2`, `m_TID = 8`, and `m_TLAST` on the 4th beat. `busy` falls after the TLAST accept.
- **Round-robin.** All 4 sources hold 2-beat packets continuously → `m_TDEST` sequence 0,0,1,1,2,2,3,3,0,0, with one idle cycle between packets.
- **Backpressure.** `m_TREADY` is low for 5 cycles mid-packet → `m_*` stable and `s_TREADY[g] = 0` throughout. No beat is lost or duplicated; data order is preserved.
- **Stalled source.** Source 1 drops TVALID for 3 cycles mid-packet while source 3 is valid → source 3's `s_TREADY` stays 0. Source 1 completes its packet, then source 3 is granted.
- **Reset mid-packet.** Assert `ARESETn = 0` at beat 2 of 6 → `m_TVALID` and `s_TREADY` go 0 immediately. After release, source 0 is granted first.
